// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - lock/health checker for a 4-bit one-hot ring counter
//
// Samples the ring counter output every clock. After one legal code and then
// LOCK_CNT in-sequence codes it declares lock. It reports the phase index,
// counts revolutions while locked and raises a sticky error with the cause of
// the first fault.
//
// Parameters:
//   LOCK_CNT  in-sequence samples after the first legal one needed to lock (1..15)
//   REV_W     width of the revolution counter
//   DIR       0: rotation toward MSB, 1: rotation toward LSB
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   q          ring counter output
//   clr        synchronous clear of err, err_code and rev_count
//   locked     high while in LOCKED
//   idx        bit position of the last legal sample
//   rev_count  revolutions seen while locked (wraps)
//   err        sticky fault flag
//   err_code   first-fault cause: 00 none, 01 illegal code, 10 sequence error

module ring_monitor #(
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 8,
    parameter int DIR      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       q,
    input  logic             clr,
    output logic             locked,
    output logic [1:0]       idx,
    output logic [REV_W-1:0] rev_count,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

    state_t           state_q, state_d;
    logic [3:0]       streak_q, streak_d;
    logic [3:0]       prev_q;
    logic             locked_q, locked_d;
    logic [1:0]       idx_q, idx_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic       legal;
    logic       seq_ok;
    logic [3:0] rot_prev;
    logic [3:0] streak_inc;
    logic       fault;
    logic       rev_inc;
    logic [1:0] cause;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign legal      = (q != 4'b0000) && ((q & (q - 4'd1)) == 4'b0000);
    assign rot_prev   = (DIR == 0) ? {prev_q[2:0], prev_q[3]} : {prev_q[0], prev_q[3:1]};
    assign seq_ok     = legal && (q == rot_prev);
    assign streak_inc = streak_q + 4'd1;
    assign cause      = legal ? 2'b10 : 2'b01;
    // Based on the pre-edge state, so the edge that enters LOCKED never counts.
    assign rev_inc    = (state_q == S_LOCKED) && seq_ok && (q == 4'b0001);

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        fault    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (legal) begin
                    state_d  = S_ACQ;
                    streak_d = 4'd0;
                end
            end
            S_ACQ: begin
                if (seq_ok) begin
                    streak_d = streak_inc;
                    if (streak_inc == LOCK_TARGET) begin
                        state_d = S_LOCKED;
                    end
                end else if (legal) begin
                    streak_d = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (!seq_ok) begin
                    state_d = S_FAULT;
                    fault   = 1'b1;
                end
            end
            S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        locked_d = (state_d == S_LOCKED);

        idx_d = idx_q;
        case (q)
            4'b0001: idx_d = 2'd0;
            4'b0010: idx_d = 2'd1;
            4'b0100: idx_d = 2'd2;
            4'b1000: idx_d = 2'd3;
            default: idx_d = idx_q;
        endcase

        // A fault on the clearing edge wins; otherwise only the first cause is kept.
        err_d  = err_q;
        code_d = code_q;
        if (fault) begin
            err_d  = 1'b1;
            code_d = (err_q && !clr) ? code_q : cause;
        end else if (clr) begin
            err_d  = 1'b0;
            code_d = 2'b00;
        end

        rev_d = rev_q;
        if (clr) begin
            rev_d = '0;
        end else if (rev_inc) begin
            rev_d = rev_q + REV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            streak_q <= 4'd0;
            prev_q   <= 4'b0000;
            locked_q <= 1'b0;
            idx_q    <= 2'd0;
            rev_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            prev_q   <= q;
            locked_q <= locked_d;
            idx_q    <= idx_d;
            rev_q    <= rev_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign locked    = locked_q;
    assign idx       = idx_q;
    assign rev_count = rev_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule
